mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 4, is the maximum number of consecutive cycles ext_req may wait before it is forced ahead of the CPU.
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 cpu_req  input  1  MEM-stage access pending (rd_en or mem_wrt_en).
REQ-005 cpu_we  input  1  CPU access is a write.
REQ-006 cpu_addr, cpu_wdata  input  32 each  CPU address and store data.
REQ-007 cpu_width  input  2  CPU access width code, passed through to memory.
REQ-008 cpu_stall  output  1  holds the EX/MEM pipeline register; drives stall_mem.
REQ-009 cpu_rdata  output  32  CPU load data.
REQ-010 ext_req, ext_we  input  1 each  external master (display/peripheral) request and write flag.
REQ-011 ext_addr, ext_wdata  input  32 each  external master address and write data.
REQ-012 ext_gnt  output  1  external command accepted this cycle.
REQ-013 ext_rvalid  output  1  ext_rdata valid this cycle.
REQ-014 ext_rdata  output  32  external load data.
REQ-015 mem_en, mem_we  output  1 each  memory port strobe and write enable.
REQ-016 mem_addr, mem_wdata  output  32 each  memory address and write data; mem_width  output  2  access width (ext accesses always word, 2'b10).
REQ-017 mem_rdata  input  32  memory read data, valid one cycle after a read command.

Function
REQ-018 The FSM shall have states IDLE, CPU_DATA, EXT_DATA; one memory command per cycle at most.
REQ-019 Each cycle, arbitration shall select ext when ext_req and (not cpu_eligible or ext_wait >= STARVE_MAX), otherwise CPU when cpu_eligible; cpu_eligible = cpu_req and state != CPU_DATA.
REQ-020 The granted requester's command shall drive mem_* combinationally in the grant cycle; no grant -> mem_en=0, mem_we=0.
REQ-021 A granted read shall move the FSM to CPU_DATA/EXT_DATA for exactly one cycle, during which cpu_rdata/ext_rdata = mem_rdata (ext_rvalid=1 for EXT_DATA); a granted write or no grant shall move it to IDLE.
REQ-022 Arbitration shall also occur in CPU_DATA and EXT_DATA, giving one access per cycle back-to-back.
REQ-023 cpu_stall = cpu_req and not (CPU write granted this cycle or state == CPU_DATA); CPU reads therefore take 2 cycles and writes take 1 cycle when uncontended.
REQ-024 ext_gnt shall be 1 exactly in the cycle an ext command is driven to memory; ext_req may drop only after ext_gnt.
REQ-025 ext_wait (width clog2(STARVE_MAX+1)) shall increment, saturating at STARVE_MAX, each cycle ext_req=1 and ext_gnt=0, and clear on ext_gnt or ext_req=0.
REQ-026 Simultaneous requests with ext_wait < STARVE_MAX: CPU wins; with ext_wait = STARVE_MAX: ext wins and the CPU stays stalled.
REQ-027 cpu_rdata and ext_rdata shall hold their last values outside their data cycles.

Reset
REQ-028 With rst=1 at a posedge, state=IDLE and ext_wait=0; while rst=1, cpu_stall, ext_gnt, ext_rvalid, mem_en and mem_we shall be 0; cpu_rdata and ext_rdata shall reset to 0.
REQ-029 Reset asserted mid-access shall discard the pending data cycle; no ext_rvalid shall be produced for it.

Structure
REQ-030 The state enum and the width code WORD=2'b10 shall live in a shared processor package; STARVE_MAX is a module parameter.
REQ-031 The starvation counter shall be one sub-module, arb_starve_cnt; the FSM and muxing stay in mem_arbiter.

Verification
REQ-032 CPU read 0x100, mem returns 0xDEADBEEF, no ext -> cpu_stall=1 in cycle 0, cpu_rdata=0xDEADBEEF and cpu_stall=0 in cycle 1.
REQ-033 CPU write 0x200 = 0x12345678 -> mem_we=1, cpu_stall=0 in the same cycle; next state IDLE.
REQ-034 ext read 0x400 held while the CPU reads continuously -> ext_gnt no later than the cycle after ext_wait reaches 4; ext_rvalid one cycle after ext_gnt.
REQ-035 cpu_req and ext_req both rise with ext_wait=0 -> CPU granted first; ext granted in the next (CPU_DATA) cycle; no lost or duplicated access.
REQ-036 rst pulsed during EXT_DATA -> ext_rvalid=0, all outputs at reset values, ext_wait=0 the cycle after.
REQ-037 ext write/read back-to-back to 0x10 (write 0xA5A5A5A5) -> the read returns 0xA5A5A5A5, with one mem_en per cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states and the width code
// used for external-master accesses.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StCpuData = 2'd1,
    StExtData = 2'd2
  } arb_state_e;

  // Access-width code for a full 32-bit word
  localparam logic [1:0] WORD = 2'b10;

endpackage

// File: rtl/arb_starve_cnt.sv
// Starvation counter for the external master. It counts consecutive cycles that
// ext_req waits without a grant, saturating at STARVE_MAX.
module arb_starve_cnt #(
  parameter int unsigned STARVE_MAX = 4,
  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ext_req,
  input  logic            ext_gnt,
  output logic [CntW-1:0] ext_wait,
  output logic            starved
);

  localparam logic [CntW-1:0] MaxCnt = CntW'(STARVE_MAX);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear when ext is idle or served, otherwise count up and saturate
  always_comb begin
    cnt_d = cnt_q;
    if (!ext_req || ext_gnt) begin
      cnt_d = '0;
    end else if (cnt_q < MaxCnt) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign ext_wait = cnt_q;
  assign starved  = (cnt_q >= MaxCnt);

endmodule

// File: rtl/mem_arbiter.sv
// Data-memory arbiter between the CPU MEM stage and an external master.
// One memory command per cycle; reads return data in the following cycle,
// which is tracked by the CpuData/ExtData states.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [1:0]  cpu_width,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  // External master side
  input  logic        ext_req,
  input  logic        ext_we,
  input  logic [31:0] ext_addr,
  input  logic [31:0] ext_wdata,
  output logic        ext_gnt,
  output logic        ext_rvalid,
  output logic [31:0] ext_rdata,
  // Memory port
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [1:0]  mem_width,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CntW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  arb_state_e      state_q, state_d;
  logic [CntW-1:0] ext_wait;
  logic            starved;
  logic            cpu_eligible;
  logic            ext_sel;
  logic            cpu_sel;
  logic [31:0]     cpu_rdata_q;
  logic [31:0]     ext_rdata_q;

  arb_starve_cnt #(
    .STARVE_MAX(STARVE_MAX)
  ) u_starve (
    .clk      (clk),
    .rst      (rst),
    .ext_req  (ext_req),
    .ext_gnt  (ext_gnt),
    .ext_wait (ext_wait),
    .starved  (starved)
  );

  // State register and hold registers for the last load data of each requester
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == StCpuData) cpu_rdata_q <= mem_rdata;
      if (state_q == StExtData) ext_rdata_q <= mem_rdata;
    end
  end

  // Arbitration, memory command mux, next state and requester outputs
  always_comb begin
    state_d      = StIdle;
    mem_en       = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_width    = '0;
    ext_gnt      = 1'b0;
    ext_rvalid   = 1'b0;
    cpu_stall    = 1'b0;
    cpu_rdata    = cpu_rdata_q;
    ext_rdata    = ext_rdata_q;
    // The CPU request being completed in CpuData must not be issued a second time
    cpu_eligible = cpu_req && (state_q != StCpuData);
    ext_sel      = 1'b0;
    cpu_sel      = 1'b0;

    // Reset masks every strobe and drops any pending data cycle
    if (!rst) begin
      ext_sel = ext_req && (!cpu_eligible || starved);
      cpu_sel = cpu_eligible && !ext_sel;

      if (ext_sel) begin
        mem_en    = 1'b1;
        mem_we    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
        mem_width = WORD;
        ext_gnt   = 1'b1;
        if (!ext_we) state_d = StExtData;
      end else if (cpu_sel) begin
        mem_en    = 1'b1;
        mem_we    = cpu_we;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_width = cpu_width;
        if (!cpu_we) state_d = StCpuData;
      end

      cpu_stall = cpu_req && !((cpu_sel && cpu_we) || (state_q == StCpuData));

      if (state_q == StCpuData) begin
        cpu_rdata = mem_rdata;
      end
      if (state_q == StExtData) begin
        ext_rvalid = 1'b1;
        ext_rdata  = mem_rdata;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed stimulus pushes expected memory
// commands and load data into queues; a monitor pops and compares them whenever
// the DUT presents a command or load data. Cycle-exact timing checks are done
// inline by the stimulus.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  width;
  } cmd_t;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic [1:0]  cpu_width;
  logic        cpu_stall;
  logic [31:0] cpu_rdata;
  logic        ext_req, ext_we;
  logic [31:0] ext_addr, ext_wdata;
  logic        ext_gnt, ext_rvalid;
  logic [31:0] ext_rdata;
  logic        mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_width;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

  cmd_t        exp_cmd [$];
  logic [31:0] exp_cpu [$];
  logic [31:0] exp_ext [$];

  logic [31:0] mem_array [1024];

  // Starvation scenario: CPU write index, ext_req, expected ext_gnt/stall/wait/rvalid
  int unsigned st_k      [6] = '{0, 1, 2, 3, 4, 4};
  logic        st_ereq   [6] = '{1, 1, 1, 1, 1, 0};
  logic        st_gnt    [6] = '{0, 0, 0, 0, 1, 0};
  logic        st_stall  [6] = '{0, 0, 0, 0, 1, 0};
  int unsigned st_wait   [6] = '{0, 1, 2, 3, 4, 0};
  logic        st_rvalid [6] = '{0, 0, 0, 0, 0, 1};

  mem_arbiter #(
    .STARVE_MAX(4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_width  (cpu_width),
    .cpu_stall  (cpu_stall),
    .cpu_rdata  (cpu_rdata),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rvalid (ext_rvalid),
    .ext_rdata  (ext_rdata),
    .mem_en     (mem_en),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_width  (mem_width),
    .mem_rdata  (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: one-cycle read latency, preloaded while reset is held
  always @(posedge clk) begin
    if (rst) begin
      mem_array[10'(32'h100 >> 2)] <= 32'hDEADBEEF;
      mem_array[10'(32'h300 >> 2)] <= 32'h33333333;
      mem_array[10'(32'h400 >> 2)] <= 32'h44444444;
    end else if (mem_en) begin
      if (mem_we) mem_array[mem_addr[11:2]] <= mem_wdata;
      else        mem_rdata <= mem_array[mem_addr[11:2]];
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic drive_cpu(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [1:0] width);
    cpu_req   = req;
    cpu_we    = we;
    cpu_addr  = addr;
    cpu_wdata = wdata;
    cpu_width = width;
  endtask

  task automatic drive_ext(input logic req, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    ext_req   = req;
    ext_we    = we;
    ext_addr  = addr;
    ext_wdata = wdata;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare memory commands and load data against the scoreboard
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (mem_en === 1'b1) begin
        if (exp_cmd.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL mem_cmd: unexpected command addr 0x%08h, none expected", mem_addr);
        end else begin
          cmd_t c;
          c = exp_cmd.pop_front();
          check("cmd_addr", mem_addr, c.addr);
          check("cmd_we", 32'(mem_we), 32'(c.we));
          check("cmd_width", 32'(mem_width), 32'(c.width));
          if (c.we) check("cmd_wdata", mem_wdata, c.wdata);
        end
      end
      if (cpu_req === 1'b1 && cpu_we === 1'b0 && cpu_stall === 1'b0) begin
        if (exp_cpu.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL cpu_load: unexpected completion 0x%08h, none expected", cpu_rdata);
        end else begin
          check("cpu_load", cpu_rdata, exp_cpu.pop_front());
        end
      end
      if (ext_rvalid === 1'b1) begin
        if (exp_ext.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL ext_load: unexpected rvalid 0x%08h, none expected", ext_rdata);
        end else begin
          check("ext_load", ext_rdata, exp_ext.pop_front());
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    // Requests held during reset must not reach memory
    drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, WORD);
    drive_ext(1'b1, 1'b0, 32'h400, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_cpu_stall", 32'(cpu_stall), 32'd0);
    check("rst_ext_gnt", 32'(ext_gnt), 32'd0);
    check("rst_ext_rvalid", 32'(ext_rvalid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);

    next_cycle();
    rst = 1'b0;
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_ext_rdata", ext_rdata, 32'h0);
    check("rst_wait", 32'(dut.ext_wait), 32'd0);

    // CPU read, uncontended: stall in the command cycle, data the next
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h100, 32'h0, WORD);
    exp_cmd.push_back('{we: 1'b0, addr: 32'h100, wdata: 32'h0, width: WORD});
    exp_cpu.push_back(32'hDEADBEEF);
    @(negedge clk);
    check("rd_c0_stall", 32'(cpu_stall), 32'd1);
    check("rd_c0_mem_en", 32'(mem_en), 32'd1);
    next_cycle();
    @(negedge clk);
    check("rd_c1_stall", 32'(cpu_stall), 32'd0);
    check("rd_c1_rdata", cpu_rdata, 32'hDEADBEEF);
    check("rd_c1_mem_en", 32'(mem_en), 32'd0);
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    @(negedge clk);
    check("rd_hold_rdata", cpu_rdata, 32'hDEADBEEF);

    // CPU write: single cycle, no stall
    next_cycle();
    drive_cpu(1'b1, 1'b1, 32'h200, 32'h12345678, WORD);
    exp_cmd.push_back('{we: 1'b1, addr: 32'h200, wdata: 32'h12345678, width: WORD});
    @(negedge clk);
    check("wr_mem_we", 32'(mem_we), 32'd1);
    check("wr_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    @(negedge clk);
    check("wr_next_idle", 32'(dut.state_q), 32'(StIdle));

    // External write then read back-to-back to 0x10
    next_cycle();
    drive_ext(1'b1, 1'b1, 32'h10, 32'hA5A5A5A5);
    exp_cmd.push_back('{we: 1'b1, addr: 32'h10, wdata: 32'hA5A5A5A5, width: WORD});
    @(negedge clk);
    check("extwr_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();
    drive_ext(1'b1, 1'b0, 32'h10, 32'h0);
    exp_cmd.push_back('{we: 1'b0, addr: 32'h10, wdata: 32'h0, width: WORD});
    exp_ext.push_back(32'hA5A5A5A5);
    @(negedge clk);
    check("extrd_gnt", 32'(ext_gnt), 32'd1);
    check("extrd_rvalid_early", 32'(ext_rvalid), 32'd0);
    next_cycle();
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("extrd_rvalid", 32'(ext_rvalid), 32'd1);
    check("extrd_rdata", ext_rdata, 32'hA5A5A5A5);
    check("extrd_mem_en", 32'(mem_en), 32'd0);

    // Simultaneous requests with ext_wait=0: CPU first, ext in the CpuData slot
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h300, 32'h0, 2'b01);
    drive_ext(1'b1, 1'b0, 32'h400, 32'h0);
    exp_cmd.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, width: 2'b01});
    exp_cmd.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, width: WORD});
    exp_cpu.push_back(32'h33333333);
    exp_ext.push_back(32'h44444444);
    @(negedge clk);
    check("sim_c0_ext_gnt", 32'(ext_gnt), 32'd0);
    check("sim_c0_stall", 32'(cpu_stall), 32'd1);
    check("sim_c0_ext_hold", ext_rdata, 32'hA5A5A5A5);
    next_cycle();
    @(negedge clk);
    check("sim_c1_ext_gnt", 32'(ext_gnt), 32'd1);
    check("sim_c1_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("sim_c2_rvalid", 32'(ext_rvalid), 32'd1);
    check("sim_c2_mem_en", 32'(mem_en), 32'd0);

    // Starvation: continuous CPU writes until ext_wait reaches the limit
    for (int k = 0; k < 4; k++) begin
      exp_cmd.push_back('{we: 1'b1, addr: 32'h500 + 32'(4 * k), wdata: 32'(k), width: WORD});
    end
    exp_cmd.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, width: WORD});
    exp_cmd.push_back('{we: 1'b1, addr: 32'h510, wdata: 32'd4, width: WORD});
    exp_ext.push_back(32'h44444444);
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      drive_cpu(1'b1, 1'b1, 32'h500 + 32'(4 * st_k[c]), 32'(st_k[c]), WORD);
      drive_ext(st_ereq[c], 1'b0, 32'h400, 32'h0);
      @(negedge clk);
      check($sformatf("starve_c%0d_gnt", c), 32'(ext_gnt), 32'(st_gnt[c]));
      check($sformatf("starve_c%0d_stall", c), 32'(cpu_stall), 32'(st_stall[c]));
      check($sformatf("starve_c%0d_wait", c), 32'(dut.ext_wait), 32'(st_wait[c]));
      check($sformatf("starve_c%0d_rvalid", c), 32'(ext_rvalid), 32'(st_rvalid[c]));
    end
    next_cycle();
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);

    // Reset pulsed during ExtData: data cycle discarded
    next_cycle();
    drive_cpu(1'b1, 1'b0, 32'h300, 32'h0, WORD);
    drive_ext(1'b1, 1'b0, 32'h400, 32'h0);
    exp_cmd.push_back('{we: 1'b0, addr: 32'h300, wdata: 32'h0, width: WORD});
    exp_cmd.push_back('{we: 1'b0, addr: 32'h400, wdata: 32'h0, width: WORD});
    exp_cpu.push_back(32'h33333333);
    @(negedge clk);
    check("rstx_c0_stall", 32'(cpu_stall), 32'd1);
    next_cycle();
    @(negedge clk);
    check("rstx_c1_gnt", 32'(ext_gnt), 32'd1);
    next_cycle();
    rst = 1'b1;
    drive_cpu(1'b1, 1'b1, 32'h600, 32'h66, WORD);
    drive_ext(1'b1, 1'b0, 32'h404, 32'h0);
    @(negedge clk);
    check("rstx_c2_rvalid", 32'(ext_rvalid), 32'd0);
    check("rstx_c2_mem_en", 32'(mem_en), 32'd0);
    check("rstx_c2_mem_we", 32'(mem_we), 32'd0);
    check("rstx_c2_gnt", 32'(ext_gnt), 32'd0);
    check("rstx_c2_stall", 32'(cpu_stall), 32'd0);
    next_cycle();
    rst = 1'b0;
    drive_cpu(1'b0, 1'b0, 32'h0, 32'h0, WORD);
    drive_ext(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    check("rstx_c3_rvalid", 32'(ext_rvalid), 32'd0);
    check("rstx_c3_wait", 32'(dut.ext_wait), 32'd0);
    check("rstx_c3_state", 32'(dut.state_q), 32'(StIdle));
    check("rstx_c3_cpu_rdata", cpu_rdata, 32'h0);
    check("rstx_c3_ext_rdata", ext_rdata, 32'h0);

    // Every expected command and load must have been consumed
    repeat (3) next_cycle();
    @(negedge clk);
    check("left_cmd", 32'(exp_cmd.size()), 32'd0);
    check("left_cpu", 32'(exp_cpu.size()), 32'd0);
    check("left_ext", 32'(exp_ext.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
